// File: rtl/axi_boot_loader.sv
// rtl/axi_boot_loader.sv - Holds the CPU in reset, streams a boot image into RAM as AXI4 INCR bursts, then releases the CPU.
module axi_boot_loader #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 64,
    parameter int                ID_W        = 4,
    parameter int                AXI_ID      = 0,
    parameter logic [ADDR_W-1:0] LOAD_BASE   = 32'h0000_0000,
    parameter int                BURST_LEN   = 16,
    parameter int                COUNT_W     = 20,
    parameter int                RELEASE_DLY = 4
) (
    input  logic                i_aclk,
    input  logic                i_aresetn,
    input  logic                i_start,
    input  logic [COUNT_W-1:0]  i_word_count,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [DATA_W-1:0]   i_s_data,
    output logic                o_aw_valid,
    input  logic                i_aw_ready,
    output logic [ID_W-1:0]     o_aw_id,
    output logic [ADDR_W-1:0]   o_aw_addr,
    output logic [7:0]          o_aw_len,
    output logic [2:0]          o_aw_size,
    output logic [1:0]          o_aw_burst,
    output logic                o_w_valid,
    input  logic                i_w_ready,
    output logic [DATA_W-1:0]   o_w_data,
    output logic [DATA_W/8-1:0] o_w_strb,
    output logic                o_w_last,
    input  logic                i_b_valid,
    output logic                o_b_ready,
    input  logic [ID_W-1:0]     i_b_id,
    input  logic [1:0]          i_b_resp,
    output logic                o_cpu_resetn,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_REL, S_DONE, S_ERR} state_t;

    localparam logic [COUNT_W-1:0] BL_C  = COUNT_W'(BURST_LEN);
    localparam int                 DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

    state_t              r_state;
    logic [COUNT_W-1:0]  r_remaining;
    logic [ADDR_W-1:0]   r_addr;
    logic [8:0]          r_beats;
    logic [8:0]          r_beat_cnt;
    logic [7:0]          r_aw_len;
    logic                r_aw_valid;
    logic                r_b_ready;
    logic [DLY_W-1:0]    r_dly_cnt;
    logic                r_cpu_resetn;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [COUNT_W-1:0]  w_rem_src;
    logic [8:0]          w_beats_new;
    logic                w_beat_hs;
    logic                w_last_beat;
    logic                w_unused;

    // Next burst size: full burst or whatever is left, from word_count in IDLE else from remaining.
    assign w_rem_src   = (r_state == S_IDLE) ? i_word_count : r_remaining;
    assign w_beats_new = (w_rem_src >= BL_C) ? 9'(BURST_LEN) : w_rem_src[8:0];
    assign w_beat_hs   = (r_state == S_W) && i_s_valid && i_w_ready;
    assign w_last_beat = (r_beat_cnt == r_beats - 9'd1);
    assign w_unused    = ^i_b_id;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_addr       <= '0;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_aw_len     <= '0;
            r_aw_valid   <= 1'b0;
            r_b_ready    <= 1'b0;
            r_dly_cnt    <= '0;
            r_cpu_resetn <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_word_count != '0) begin
                            r_remaining <= i_word_count;
                            r_addr      <= LOAD_BASE;
                            r_beats     <= w_beats_new;
                            r_aw_len    <= 8'(w_beats_new - 9'd1);
                            r_beat_cnt  <= '0;
                            r_aw_valid  <= 1'b1;
                            r_state     <= S_AW;
                        end else begin
                            r_dly_cnt <= '0;
                            r_state   <= S_REL;
                        end
                    end
                end
                S_AW: begin
                    if (i_aw_ready) begin
                        r_aw_valid <= 1'b0;
                        r_state    <= S_W;
                    end
                end
                S_W: begin
                    if (w_beat_hs) begin
                        if (w_last_beat) begin
                            r_remaining <= r_remaining - COUNT_W'(r_beats);
                            r_addr      <= r_addr + ADDR_W'({r_beats, 3'b000});
                            r_b_ready   <= 1'b1;
                            r_state     <= S_B;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                S_B: begin
                    if (i_b_valid) begin
                        r_b_ready <= 1'b0;
                        if (i_b_resp[1]) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else if (r_remaining == '0) begin
                            r_dly_cnt <= '0;
                            r_state   <= S_REL;
                        end else begin
                            r_beats    <= w_beats_new;
                            r_aw_len   <= 8'(w_beats_new - 9'd1);
                            r_beat_cnt <= '0;
                            r_aw_valid <= 1'b1;
                            r_state    <= S_AW;
                        end
                    end
                end
                S_REL: begin
                    if (r_dly_cnt == DLY_W'(RELEASE_DLY - 1)) begin
                        r_cpu_resetn <= 1'b1;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_DONE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_s_ready    = (r_state == S_W) && i_w_ready;
    assign o_w_valid    = (r_state == S_W) && i_s_valid;
    assign o_w_data     = i_s_data;
    assign o_w_strb     = '1;
    assign o_w_last     = (r_state == S_W) && w_last_beat;
    assign o_aw_valid   = r_aw_valid;
    assign o_aw_id      = ID_W'(AXI_ID);
    assign o_aw_addr    = r_addr;
    assign o_aw_len     = r_aw_len;
    assign o_aw_size    = 3'd3;
    assign o_aw_burst   = 2'b01;
    assign o_b_ready    = r_b_ready;
    assign o_cpu_resetn = r_cpu_resetn;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
endmodule

// File: tb/tb_axi_boot_loader.sv
// tb/tb_axi_boot_loader.sv - Scoreboard bench for axi_boot_loader: directed loads, stalls, error and reset abort.
module tb_axi_boot_loader;
    localparam int DLY = 4;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_start = 1'b0;
    logic [19:0] i_word_count = '0;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [63:0] i_s_data = '0;
    logic        o_aw_valid;
    logic        i_aw_ready = 1'b0;
    logic [3:0]  o_aw_id;
    logic [31:0] o_aw_addr;
    logic [7:0]  o_aw_len;
    logic [2:0]  o_aw_size;
    logic [1:0]  o_aw_burst;
    logic        o_w_valid;
    logic        i_w_ready = 1'b0;
    logic [63:0] o_w_data;
    logic [7:0]  o_w_strb;
    logic        o_w_last;
    logic        i_b_valid = 1'b0;
    logic        o_b_ready;
    logic [3:0]  i_b_id = '0;
    logic [1:0]  i_b_resp = '0;
    logic        o_cpu_resetn;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    axi_boot_loader #(.RELEASE_DLY(DLY)) dut (
        .i_aclk(clk), .i_aresetn(aresetn), .i_start(i_start), .i_word_count(i_word_count),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_id(o_aw_id), .o_aw_addr(o_aw_addr),
        .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
        .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data), .o_w_strb(o_w_strb),
        .o_w_last(o_w_last), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_id(i_b_id),
        .i_b_resp(i_b_resp), .o_cpu_resetn(o_cpu_resetn), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int   src_n = 0, tnum = 0, aw_hold = 0;
    bit   sv_tog = 1'b0, wr_rand = 1'b0;
    logic [1:0] bresp = 2'b00;

    int src_idx = 0, pending = 0, awcnt = 0;
    bit tog = 1'b0;

    int aw_cnt = 0, w_cnt = 0, awv_cyc = 0, crst_hi = 0, b_edge = 0, rise_cyc = 0, outst = 0;
    bit prev_awv = 1'b0, prev_awhs = 1'b0, prev_crst = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic last; } w_t;
    aw_t exp_aw[$];
    w_t  exp_w[$];

    function automatic logic [63:0] word(int t, int i);
        return {16'hB007, 8'(t), 8'h00, 32'(i)};
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void push_aw(logic [31:0] a, logic [7:0] l);
        aw_t e;
        e.addr = a;
        e.len  = l;
        exp_aw.push_back(e);
    endfunction

    // Burst boundaries fall every 16 words and at the final word.
    function automatic void push_w(int n, int t);
        w_t e;
        for (int i = 0; i < n; i++) begin
            e.data = word(t, i);
            e.last = ((i % 16) == 15) || (i == n - 1);
            exp_w.push_back(e);
        end
    endfunction

    // Image source, AW/W ready generator and B responder.
    initial begin
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                src_idx = 0; pending = 0; awcnt = 0;
            end else begin
                if (i_s_valid && o_s_ready) src_idx++;
                if (o_aw_valid && i_aw_ready) awcnt = 0;
                else if (o_aw_valid) awcnt++;
                if (o_w_valid && i_w_ready && o_w_last) pending++;
                if (i_b_valid && o_b_ready) pending--;
            end
            @(posedge clk);
            #1;
            tog        = !tog;
            i_s_valid  = (src_idx < src_n) && (!sv_tog || tog);
            i_s_data   = i_s_valid ? word(tnum, src_idx) : 64'h0;
            i_w_ready  = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_aw_ready = (awcnt >= aw_hold);
            i_b_valid  = (pending > 0);
            i_b_resp   = bresp;
        end
    end

    // Monitor: pops the scoreboard on every AW and W handshake.
    initial begin
        aw_t ea;
        w_t  ew;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_awv = 1'b0; prev_awhs = 1'b0; prev_crst = 1'b0; outst = 0;
            end else begin
                if (o_aw_valid) begin
                    awv_cyc++;
                    if (prev_awv && !prev_awhs) begin
                        chk("aw_addr_stable", o_aw_addr, prev_addr);
                        chk("aw_len_stable", o_aw_len, prev_len);
                    end
                end
                if (o_aw_valid && i_aw_ready) begin
                    aw_cnt++;
                    chk("aw_after_prev_b", outst, 0);
                    outst++;
                    if (exp_aw.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL aw_unexpected: got addr %h len %0d expected no AW", o_aw_addr, o_aw_len);
                    end else begin
                        ea = exp_aw.pop_front();
                        chk("aw_addr", o_aw_addr, ea.addr);
                        chk("aw_len", o_aw_len, ea.len);
                        chk("aw_id_size_burst", {o_aw_id, o_aw_size, o_aw_burst}, {4'h0, 3'd3, 2'b01});
                    end
                end
                prev_awv  = o_aw_valid;
                prev_awhs = o_aw_valid && i_aw_ready;
                prev_addr = o_aw_addr;
                prev_len  = o_aw_len;
                if (o_w_valid && i_w_ready) begin
                    w_cnt++;
                    if (exp_w.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL w_unexpected: got data %h expected no beat", o_w_data);
                    end else begin
                        ew = exp_w.pop_front();
                        chk("w_data", o_w_data, ew.data);
                        chk("w_last", o_w_last, ew.last);
                        chk("w_strb", o_w_strb, 8'hFF);
                    end
                end
                if (i_b_valid && o_b_ready) begin
                    b_edge = cyc + 1;
                    outst--;
                end
                if (o_cpu_resetn && !prev_crst) rise_cyc = cyc;
                if (o_cpu_resetn) crst_hi++;
                prev_crst = o_cpu_resetn;
            end
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_aw_valid"}, o_aw_valid, 0);
        chk({tag, "_w_valid"}, o_w_valid, 0);
        chk({tag, "_s_ready"}, o_s_ready, 0);
        chk({tag, "_b_ready"}, o_b_ready, 0);
        chk({tag, "_w_last"}, o_w_last, 0);
        chk({tag, "_cpu_resetn"}, o_cpu_resetn, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_error"}, o_error, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_aw.delete();
        exp_w.delete();
        aresetn = 1'b1;
    endtask

    task automatic start_load(int n, output int edge_cyc);
        @(posedge clk);
        #1;
        i_start      = 1'b1;
        i_word_count = 20'(n);
        @(negedge clk);
        edge_cyc = cyc + 1;
        @(posedge clk);
        #1;
        i_start      = 1'b0;
        i_word_count = '0;
    endtask

    task automatic wait_end(string nm, int limit);
        int n = 0;
        while (!(o_done || o_error) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_budget"}, n < limit, 1);
        @(negedge clk);
    endtask

    task automatic chk_clean_finish(string nm);
        chk({nm, "_aw_drained"}, exp_aw.size(), 0);
        chk({nm, "_w_drained"}, exp_w.size(), 0);
        chk({nm, "_done"}, o_done, 1);
        chk({nm, "_cpu_resetn"}, o_cpu_resetn, 1);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_error"}, o_error, 0);
        chk({nm, "_release_delay"}, rise_cyc - b_edge, DLY);
    endtask

    initial begin
        int se, aw0, v0, c0, w0, n;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        aresetn = 1'b1;

        // 1: three words, everything ready
        tnum = 1; src_n = 3;
        push_aw(32'h0, 8'd2);
        push_w(3, 1);
        start_load(3, se);
        @(negedge clk);
        chk("t1_aw_valid_after_start", o_aw_valid, 1);
        chk("t1_busy_after_start", o_busy, 1);
        wait_end("t1", 300);
        chk_clean_finish("t1");

        // 2: 40 words over three bursts
        do_reset();
        tnum = 2; src_n = 40;
        push_aw(32'h000, 8'd15);
        push_aw(32'h080, 8'd15);
        push_aw(32'h100, 8'd7);
        push_w(40, 2);
        start_load(40, se);
        wait_end("t2", 1000);
        chk_clean_finish("t2");

        // 3: AW stall, gapped source, random W ready
        do_reset();
        tnum = 3; src_n = 20; aw_hold = 5; sv_tog = 1'b1; wr_rand = 1'b1;
        push_aw(32'h000, 8'd15);
        push_aw(32'h080, 8'd3);
        push_w(20, 3);
        start_load(20, se);
        wait_end("t3", 2000);
        chk_clean_finish("t3");

        // 4: SLVERR on the first B
        do_reset();
        tnum = 4; src_n = 20; aw_hold = 0; sv_tog = 1'b0; wr_rand = 1'b0; bresp = 2'b10;
        push_aw(32'h000, 8'd15);
        push_w(16, 4);
        start_load(20, se);
        wait_end("t4", 500);
        chk("t4_error", o_error, 1);
        chk("t4_busy", o_busy, 0);
        chk("t4_s_ready", o_s_ready, 0);
        aw0 = aw_cnt; v0 = awv_cyc; c0 = crst_hi;
        repeat (100) @(negedge clk);
        chk("t4_no_more_aw", aw_cnt - aw0, 0);
        chk("t4_no_aw_valid", awv_cyc - v0, 0);
        chk("t4_cpu_held", crst_hi - c0, 0);
        chk("t4_done", o_done, 0);
        chk("t4_w_drained", exp_w.size(), 0);

        // 5: zero-length load
        do_reset();
        bresp = 2'b00; src_n = 0; tnum = 5;
        aw0 = aw_cnt; v0 = awv_cyc; w0 = w_cnt;
        start_load(0, se);
        wait_end("t5", 100);
        chk("t5_release_delay", rise_cyc - se, DLY);
        chk("t5_done", o_done, 1);
        chk("t5_cpu_resetn", o_cpu_resetn, 1);
        chk("t5_no_aw", (aw_cnt - aw0) + (awv_cyc - v0), 0);
        chk("t5_no_w", w_cnt - w0, 0);

        // 6: reset mid-burst, then a clean reload
        do_reset();
        tnum = 6; src_n = 16; sv_tog = 1'b1;
        push_aw(32'h000, 8'd15);
        push_w(16, 6);
        w0 = w_cnt;
        start_load(16, se);
        n = 0;
        while ((w_cnt - w0) < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_beat5", n < 200, 1);
        @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        repeat (2) @(posedge clk);
        #1;
        exp_aw.delete();
        exp_w.delete();
        tnum = 7; sv_tog = 1'b0;
        aresetn = 1'b1;
        push_aw(32'h000, 8'd15);
        push_w(16, 7);
        start_load(16, se);
        wait_end("t6", 500);
        chk_clean_finish("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_boot_loader.md
Name: axi_boot_loader

Overview:
- Boot-time reset sequencer that sits between the program-image source and the AXI RAM on the same memory port as the Rocket core.
- Holds the CPU in reset and streams a program image (64-bit words) into RAM as AXI4 INCR write bursts.
- After the last write response it waits a fixed delay, then releases the CPU reset.
- Replaces bench-side memory preloading with a synthesizable load path.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI data / stream word width (fixed 64; aw_size=3)
ID_W, 4, AXI ID width
AXI_ID, 0, constant ID driven on aw_id
LOAD_BASE, 32'h0000_0000, byte address of first word; must be aligned to BURST_LEN*8
BURST_LEN, 16, max beats per burst (1..256)
COUNT_W, 20, width of word_count
RELEASE_DLY, 4, cycles from final B handshake to cpu_resetn rise (>=1)

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
start  in  1  pulse; begin load (sampled in IDLE only)
word_count  in  COUNT_W  number of 64-bit words to load, sampled with start
s_valid  in  1  image stream word valid
s_ready  out  1  image stream word accepted
s_data  in  DATA_W  image word
aw_valid  out  1  AXI AW valid
aw_ready  in  1  AXI AW ready
aw_id  out  ID_W  =AXI_ID
aw_addr  out  ADDR_W  burst start address
aw_len  out  8  beats-1
aw_size  out  3  constant 3
aw_burst  out  2  constant 2'b01 (INCR)
w_valid  out  1  AXI W valid
w_ready  in  1  AXI W ready
w_data  out  DATA_W  =s_data
w_strb  out  DATA_W/8  all ones
w_last  out  1  last beat of burst
b_valid  in  1  AXI B valid
b_ready  out  1  AXI B ready
b_id  in  ID_W  ignored
b_resp  in  2  write response
cpu_resetn  out  1  active-low reset to CPU wrapper
busy  out  1  load in progress
done  out  1  sticky; CPU released
error  out  1  sticky; bad write response

Behaviour:
- Reset (aresetn=0, async): state=IDLE. aw_valid=0, w_valid=0, s_ready=0, b_ready=0, w_last=0, cpu_resetn=0, busy=0, done=0, error=0, all counters 0. Asserting reset mid-operation aborts the load immediately and holds the CPU in reset.
- States: IDLE, AW, W, B, REL, DONE, ERR.
- IDLE:
  - start=1 and word_count!=0 → latch remaining=word_count, addr=LOAD_BASE; go to AW; busy=1 from the next cycle.
  - start=1 and word_count==0 → go to REL.
  - start is ignored in all other states.
- AW:
  - Entered with beats=min(BURST_LEN, remaining).
  - aw_valid=1, aw_addr=addr, aw_len=beats-1, all registered.
  - All AW fields stay stable until aw_ready. On handshake: aw_valid=0 next cycle; go to W.
  - aw_valid asserts the cycle after start is accepted.
- W:
  - w_valid=s_valid and s_ready=w_ready, both combinational; w_data=s_data.
  - A beat completes when s_valid&&w_ready; beat counter increments.
  - w_last=1 when beat counter==beats-1.
  - On the last-beat handshake: remaining-=beats, addr+=beats*8; go to B.
  - Gaps on s_valid or w_ready are legal and never drop or duplicate a word.
- B:
  - b_ready=1.
  - On b_valid, b_resp in {00,01}: if remaining==0 go to REL, else go to AW.
  - On b_valid, b_resp in {10,11}: go to ERR.
- REL:
  - Counts RELEASE_DLY cycles.
  - On exit: cpu_resetn=1, done=1, busy=0; go to DONE.
  - cpu_resetn rises exactly RELEASE_DLY cycles after the final B handshake edge.
- DONE: terminal until aresetn. cpu_resetn=1, done=1.
- ERR: terminal until aresetn. error=1, busy=0, cpu_resetn stays 0. No further AW is issued and s_ready=0.
- Single outstanding burst only. No AW is issued before the previous B is received.
- Bursts never cross 4 KB, guaranteed by LOAD_BASE alignment.
- addr wraps modulo 2^ADDR_W and is not checked.
- The final partial burst uses aw_len=remaining-1.

Test Plan:
1. word_count=3, start, aw_ready/w_ready/s_valid tied 1, b_resp=00 → one AW at addr 0x0 with aw_len=2; 3 W beats, w_last on the 3rd only; cpu_resetn=1 and done=1 exactly 4 cycles after the B handshake.
2. word_count=40 → three AWs: addr 0x000 len 15, addr 0x080 len 15, addr 0x100 len 7. Each AW follows the preceding B. 40 words land in order.
3. aw_ready held low 5 cycles; s_valid toggling 1/0 and w_ready random → aw_addr/aw_len stable while aw_valid=1; w_data sequence equals s_data sequence with no loss.
4. word_count=20, b_resp=2'b10 on the first B → error=1, no second AW, cpu_resetn stays 0 for 100 cycles, done=0.
5. word_count=0, start → no AXI traffic; done=1 and cpu_resetn=1 RELEASE_DLY cycles after start plus the IDLE→REL edge.
6. aresetn pulsed low mid-W (beat 5 of 16) → all outputs return to reset values asynchronously; after release, a new start with word_count=16 completes normally from LOAD_BASE.
